edge_stream_detector: RTL and testbench

EDGE_STREAM_DETECTOR -- requirements
Module: edge_stream_detector

---
 rtl/edge_pkg.sv | 27 ++
 rtl/sobel_kernel.sv | 36 +++
 rtl/edge_stream_detector.sv | 181 ++++++++++++++++++
 tb/tb_edge_stream_detector.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_pkg
// Purpose  : Shared types and constants for the streaming Sobel edge detector.
// Revision : 1.0 - initial release
// ============================================================================
package edge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Gradient/magnitude types at the default 8-bit pixel width; the
  // parameterised datapath sizes its own copies from PIXEL_W.
  localparam int c_PIX_W_DEF = 8;
  typedef logic signed [c_PIX_W_DEF+2:0] grad_t;
  typedef logic        [c_PIX_W_DEF+2:0] mag_t;

  localparam logic [1:0] c_DIR_HORZ      = 2'd0;
  localparam logic [1:0] c_DIR_VERT      = 2'd1;
  localparam logic [1:0] c_DIR_DIAG_SAME = 2'd2;
  localparam logic [1:0] c_DIR_DIAG_OPP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sobel_kernel.sv
`default_nettype none
// ============================================================================
// Module   : sobel_kernel
// Purpose  : Combinational 3x3 Sobel operator; window row 0 is the top line,
//            column 0 the leftmost pixel.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_kernel
  import edge_pkg::*;
#(
  parameter int PIXEL_W = 8
) (
  input  logic        [PIXEL_W-1:0] i_win [3][3],
  output logic signed [PIXEL_W+2:0] o_gx,
  output logic signed [PIXEL_W+2:0] o_gy
);

  localparam int GW = PIXEL_W + 3;

  logic signed [GW-1:0] w_p [3][3];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_p[r][c] = $signed({3'b000, i_win[r][c]});
      end
    end
  end

  assign o_gx = (w_p[0][2] + (w_p[1][2] <<< 1) + w_p[2][2])
              - (w_p[0][0] + (w_p[1][0] <<< 1) + w_p[2][0]);
  assign o_gy = (w_p[2][0] + (w_p[2][1] <<< 1) + w_p[2][2])
              - (w_p[0][0] + (w_p[0][1] <<< 1) + w_p[0][2]);

endmodule
`default_nettype wire

// File: rtl/edge_stream_detector.sv
`default_nettype none
// ============================================================================
// Module   : edge_stream_detector
// Purpose  : Raster-stream Sobel edge detector with 2-stage result pipeline.
//            Optional direction output enabled by EDGE_STREAM_DIR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module edge_stream_detector
  import edge_pkg::*;
#(
  parameter int PIXEL_W        = 8,
  parameter int MAX_LINE       = 64,
  parameter int THRESH_DEFAULT = 100
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [$clog2(MAX_LINE+1)-1:0] cfg_line_len_i,
  input  logic [PIXEL_W+2:0]            cfg_threshold_i,
  input  logic                          pix_valid_i,
  output logic                          pix_ready_o,
  input  logic [PIXEL_W-1:0]            pix_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          out_edge_o,
  output logic [PIXEL_W+2:0]            out_mag_o,
`ifdef EDGE_STREAM_DIR_EN
  output logic [1:0]                    out_dir_o,
`endif
  output logic                          busy_o
);

  localparam int LW = $clog2(MAX_LINE + 1);
  localparam int CW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
  localparam int GW = PIXEL_W + 3;

  state_t               r_state;
  logic                 r_busy;
  logic [LW-1:0]        r_len;
  logic [GW-1:0]        r_thr;
  logic [CW-1:0]        r_col;
  logic [1:0]           r_row;
  logic [PIXEL_W-1:0]   r_lb0 [MAX_LINE];
  logic [PIXEL_W-1:0]   r_lb1 [MAX_LINE];
  logic [PIXEL_W-1:0]   r_win [3][3];
  logic                 r_win_vld, r_s1_vld, r_out_vld;
  logic signed [GW-1:0] r_gx, r_gy;
  logic [GW-1:0]        r_mag;
  logic                 r_edge;

  logic signed [GW-1:0] w_gx, w_gy;
  logic                 w_adv, w_accept, w_col_last, w_qual;
  logic [PIXEL_W-1:0]   w_top, w_mid;
  logic [GW-1:0]        w_ax, w_ay, w_mag;
  logic [GW:0]          w_sum;

  // The whole pipeline advances together whenever the output slot can move.
  assign w_adv       = !r_out_vld || out_ready_i;
  assign pix_ready_o = r_busy && !start_i && w_adv;
  assign w_accept    = pix_valid_i && pix_ready_o;
  assign w_col_last  = (LW'(r_col) == (r_len - LW'(1)));
  assign w_qual      = (r_row == 2'd2) && (r_col >= CW'(2));
  assign w_top       = r_lb1[r_col];
  assign w_mid       = r_lb0[r_col];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_len   <= LW'(MAX_LINE);
      r_thr   <= GW'(THRESH_DEFAULT);
      r_col   <= '0;
      r_row   <= '0;
    end else if (start_i) begin
      r_state <= ST_FILL;
      r_busy  <= 1'b1;
      r_len   <= cfg_line_len_i;
      r_thr   <= cfg_threshold_i;
      r_col   <= '0;
      r_row   <= '0;
    end else if (w_accept) begin
      if (r_state == ST_FILL && w_qual) begin
        r_state <= ST_RUN;
      end
      if (w_col_last) begin
        r_col <= '0;
        if (r_row != 2'd2) begin
          r_row <= r_row + 2'd1;
        end
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // After a shift the window holds rows r-2..r and columns c-2..c.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_lb1[r_col] <= w_mid;
      r_lb0[r_col] <= pix_data_i;
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_top;
      r_win[1][2] <= w_mid;
      r_win[2][2] <= pix_data_i;
    end
  end

  sobel_kernel #(
    .PIXEL_W (PIXEL_W)
  ) u_sobel (
    .i_win (r_win),
    .o_gx  (w_gx),
    .o_gy  (w_gy)
  );

  assign w_ax  = r_gx[GW-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
  assign w_ay  = r_gy[GW-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
  assign w_sum = {1'b0, w_ax} + {1'b0, w_ay};
  assign w_mag = w_sum[GW] ? {GW{1'b1}} : w_sum[GW-1:0];

`ifdef EDGE_STREAM_DIR_EN
  logic [1:0] w_dir, r_dir;

  always_comb begin
    w_dir = c_DIR_DIAG_OPP;
    if (w_ay <= (w_ax >> 1)) begin
      w_dir = c_DIR_HORZ;
    end else if (w_ax <= (w_ay >> 1)) begin
      w_dir = c_DIR_VERT;
    end else if (r_gx[GW-1] == r_gy[GW-1]) begin
      w_dir = c_DIR_DIAG_SAME;
    end
  end

  assign out_dir_o = r_dir;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_win_vld <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_out_vld <= 1'b0;
      r_gx      <= '0;
      r_gy      <= '0;
      r_mag     <= '0;
      r_edge    <= 1'b0;
`ifdef EDGE_STREAM_DIR_EN
      r_dir     <= c_DIR_HORZ;
`endif
    end else if (start_i) begin
      r_win_vld <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (w_adv) begin
      r_win_vld <= w_accept && w_qual;
      r_s1_vld  <= r_win_vld;
      r_out_vld <= r_s1_vld;
      if (r_win_vld) begin
        r_gx <= w_gx;
        r_gy <= w_gy;
      end
      if (r_s1_vld) begin
        r_mag  <= w_mag;
        r_edge <= (w_mag > r_thr);
`ifdef EDGE_STREAM_DIR_EN
        r_dir  <= w_dir;
`endif
      end
    end
  end

  assign out_valid_o = r_out_vld;
  assign out_edge_o  = r_edge;
  assign out_mag_o   = r_mag;
  assign busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_edge_stream_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_stream_detector
// Purpose  : Self-checking bench: image-level Sobel model plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_stream_detector;

  localparam int PW = 8;
  localparam int ML = 64;
  localparam int LW = $clog2(ML + 1);
  localparam int GW = PW + 3;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic          pix_valid = 1'b0, out_ready = 1'b1;
  logic [LW-1:0] cfg_len = LW'(4);
  logic [GW-1:0] cfg_thr = GW'(100);
  logic [PW-1:0] pix_data = '0;
  logic          pix_ready, out_valid, out_edge, busy;
  logic [GW-1:0] out_mag;
`ifdef EDGE_STREAM_DIR_EN
  logic [1:0]    out_dir;
`endif

  always #5 clk = ~clk;

  edge_stream_detector #(.PIXEL_W(PW), .MAX_LINE(ML), .THRESH_DEFAULT(100)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .cfg_line_len_i(cfg_len), .cfg_threshold_i(cfg_thr),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready), .pix_data_i(pix_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_edge_o(out_edge), .out_mag_o(out_mag),
`ifdef EDGE_STREAM_DIR_EN
    .out_dir_o(out_dir),
`endif
    .busy_o(busy)
  );

  typedef struct { int mag; int edge_; int dir; } exp_t;

  int   total = 0, bad = 0, cyc = 0, n_out = 0;
  int   last_mag = 0, last_edge = 0, last_lat = -1, acc_cyc = 0;
  exp_t q[$];
  int   img[16][64];
  int   m_len = 64, m_thr = 100, m_r = 0, m_c = 0;
  bit   m_busy = 1'b0;
  bit   prev_stall = 1'b0, prev_start = 1'b0, prev_ov = 1'b0;
  int   prev_mag = 0, prev_edge = 0;
  bit   rnd_rdy = 1'b0, gap_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Expected result for centre (r-1,c-1) straight from the stored image.
  task automatic model_push(input int r, input int c);
    int gx, gy, ax, ay, mag;
    exp_t e;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mag = ax + ay;
    if (mag > (1 << GW) - 1) mag = (1 << GW) - 1;
    e.mag   = mag;
    e.edge_ = (mag > m_thr) ? 1 : 0;
    if (ay <= ax / 2)              e.dir = 0;
    else if (ax <= ay / 2)         e.dir = 1;
    else if ((gx < 0) == (gy < 0)) e.dir = 2;
    else                           e.dir = 3;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_busy = 1'b0; prev_stall = 1'b0; prev_start = 1'b0; prev_ov = 1'b0;
    end else begin
      if (prev_start) chk("abort_drop", out_valid, 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_mag", out_mag, prev_mag);
        chk("stall_edge", out_edge, prev_edge);
      end
      if (out_valid && !prev_ov) last_lat = cyc - acc_cyc - 1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_mag", out_mag, e.mag);
          chk("out_edge", out_edge, e.edge_);
`ifdef EDGE_STREAM_DIR_EN
          chk("out_dir", out_dir, e.dir);
`endif
        end
        n_out++;
        last_mag = out_mag;
        last_edge = out_edge;
      end
      chk("busy", busy, m_busy);
      chk("pix_ready", pix_ready, m_busy && !start && (!out_valid || out_ready));
      prev_stall = out_valid && !out_ready && !start;
      prev_mag   = out_mag;
      prev_edge  = out_edge;
      prev_ov    = out_valid;
      prev_start = start;
      if (start) begin
        q.delete();
        m_len = cfg_len; m_thr = cfg_thr; m_r = 0; m_c = 0; m_busy = 1'b1;
      end else if (pix_valid && pix_ready) begin
        img[m_r][m_c] = pix_data;
        if (m_r >= 2 && m_c >= 2) begin
          model_push(m_r, m_c);
          acc_cyc = cyc;
        end
        if (m_c == m_len - 1) begin
          m_c = 0;
          if (m_r < 15) m_r++;
        end else begin
          m_c++;
        end
      end
    end
  end

  task automatic do_start(input int len, input int thr, input bit with_pix);
    @(posedge clk); #1;
    cfg_len = LW'(len); cfg_thr = GW'(thr); start = 1'b1;
    if (with_pix) begin pix_valid = 1'b1; pix_data = 8'hAA; end
    @(posedge clk); #1;
    start = 1'b0; pix_valid = 1'b0;
    // Scramble cfg so only the latched values may matter for this frame.
    cfg_len = LW'($urandom_range(3, 64));
    cfg_thr = GW'($urandom_range(0, 2047));
  endtask

  task automatic send_pix(input int p);
    int n;
    if (gap_en) begin
      while ($urandom_range(0, 3) == 0) begin
        pix_valid = 1'b0;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    end
    pix_valid = 1'b1;
    pix_data  = PW'(p);
    n = 0;
    forever begin
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (pix_ready) begin
        @(posedge clk); #1;
        pix_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 200) begin fail("send_timeout"); pix_valid = 1'b0; break; end
    end
  endtask

  // mode 0 random, 1 constant val, 2 last column 255 else 0
  task automatic send_frame(input int len, input int rows, input int mode, input int val);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < len; c++) begin
        case (mode)
          0:       send_pix($urandom_range(0, 255));
          1:       send_pix(val);
          default: send_pix((c == len - 1) ? 255 : 0);
        endcase
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    pix_valid = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, n;
    pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_mag", out_mag, 0);
    chk("rst_out_edge", out_edge, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pix_ready", pix_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_pix_ready", pix_ready, 0);
    pix_valid = 1'b0;

    // flat image: no gradients anywhere
    base = n_out;
    do_start(4, 100, 1'b0);
    send_frame(4, 4, 1, 50);
    drain();
    chk("flat_count", n_out - base, 4);
    chk("flat_mag", last_mag, 0);
    chk("flat_edge", last_edge, 0);

    // vertical step: single interior result
    base = n_out;
    do_start(3, 100, 1'b0);
    send_frame(3, 3, 2, 0);
    drain();
    chk("step_count", n_out - base, 1);
    chk("step_mag", last_mag, 1020);
    chk("step_edge", last_edge, 1);
    chk("step_latency", last_lat, 2);

    // threshold boundary
    do_start(3, 1020, 1'b0);
    send_frame(3, 3, 2, 0);
    drain();
    chk("thr1020_edge", last_edge, 0);
    do_start(3, 1019, 1'b0);
    send_frame(3, 3, 2, 0);
    drain();
    chk("thr1019_edge", last_edge, 1);

    // back-pressure on the output
    base = n_out;
    do_start(3, 100, 1'b0);
    out_ready = 1'b0;
    fork
      send_frame(3, 4, 2, 0);
      begin
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        if (!out_valid) begin
          fail("stall_wait");
        end else begin
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_ready_low", pix_ready, 0);
            chk("stall_hold_mag", out_mag, 1020);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", n_out - base, 2);
    chk("stall_last_mag", last_mag, 1020);

    // abort after 5 pixels, with a pixel offered during start
    base = n_out;
    do_start(4, 100, 1'b0);
    for (int i = 0; i < 5; i++) send_pix($urandom_range(0, 255));
    do_start(4, 100, 1'b1);
    send_frame(4, 4, 0, 0);
    drain();
    chk("abort5_count", n_out - base, 4);

    // abort with a result in flight
    base = n_out;
    do_start(4, 50, 1'b0);
    for (int i = 0; i < 11; i++) send_pix($urandom_range(0, 255));
    do_start(4, 50, 1'b0);
    send_frame(4, 3, 0, 0);
    drain();
    chk("abort_flight_count", n_out - base, 2);

    // randomized frames with gaps and random out_ready, last at MAX_LINE
    for (int f = 0; f < 6; f++) begin
      int len, rows;
      len  = (f == 5) ? ML : $urandom_range(3, 8);
      rows = (f == 5) ? 3 : $urandom_range(3, 6);
      base = n_out;
      do_start(len, $urandom_range(0, 1500), 1'b0);
      rnd_rdy = 1'b1;
      gap_en  = 1'b1;
      send_frame(len, rows, 0, 0);
      rnd_rdy = 1'b0;
      gap_en  = 1'b0;
      drain();
      chk("rand_count", n_out - base, (rows - 2) * (len - 2));
    end

    // asynchronous reset while a result is held
    do_start(3, 100, 1'b0);
    out_ready = 1'b0;
    send_frame(3, 3, 2, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    pix_valid = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_mag", out_mag, 0);
    chk("arst_out_edge", out_edge, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pix_ready", pix_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pix_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
